gbdt_feature_sched: RTL
=======================

// Module: gbdt_feature_sched
// PURPOSE
// - Controller in front of the GBDT feature store: sequences each sample load, then shares the store's 8-lane read port.
// - Load: issues the store start, tracks header + CYCLES_NUM DMA beats, and reports load complete.
// - Read: round-robin arbitrates NUM_REQ tree-engine read requests onto fs_features_nums, then returns the 8x9b values to the winner.
// - Sits between the DMA/host control and the tree engines; it snoops dma_valid and never touches dma_data.
// PARAMETERS
// - NUM_REQ     4    number of tree-engine requesters (2..8)
// - CYCLES_NUM  16   data beats per sample load (DMA beats after the header beat)
// - TIMEOUT     255  idle cycles allowed between beats before abort (LOAD_TIMEOUT_EN only)
// PORTS
// - gbdt_clk         in   1             single clock; all logic on its rising edge
// - gbdt_rst         in   1             reset, synchronous and active-high
// - load_req         in   1             pulse: load the next sample
// - dma_valid        in   1             DMA beat valid (shared with the feature store)
// - fs_start         out  1             start strobe to the feature store
// - fs_features_nums out  8x8           feature indices driven to the store
// - fs_features_vals in   8x9           store readout (combinational from fs_features_nums)
// - load_busy        out  1             high in ARMED/LOAD/DRAIN
// - load_done        out  1             1-cycle pulse when the final data beat is accepted
// - load_err         out  1             1-cycle pulse on watchdog abort (LOAD_TIMEOUT_EN only, else tied 0)
// - rd_req           in   NUM_REQ       per-requester read request; held until granted
// - rd_nums          in   NUM_REQx8x8   per-requester feature indices, stable while rd_req is high
// - rd_gnt           out  NUM_REQ       one-hot 1-cycle grant = request accepted
// - rd_vld           out  NUM_REQ       one-hot 1-cycle pulse: rd_vals valid for that requester
// - rd_vals          out  8x9           returned feature values (shared bus)
// BEHAVIOUR
// - Reset (sync, gbdt_rst=1 at the clock edge): state=IDLE; all outputs 0; beat counter 0; RR pointer = requester NUM_REQ-1, so requester 0 wins first.
// - FSM IDLE -> ARMED on load_req.
// - ARMED: fs_start=1. On dma_valid (header beat) drop fs_start and go to LOAD with beat count 0.
// - LOAD: each dma_valid increments the count. The beat that reaches CYCLES_NUM gives load_done=1 in the next cycle; state -> READY.
// - READY: reads are granted. load_req -> DRAIN.
// - DRAIN: no new grants; go to ARMED once both read pipeline stages are empty (at most 2 cycles).
// - load_req pulses in ARMED, LOAD or DRAIN are ignored; no queueing.
// - Read pipeline, only in READY:
//   - Cycle t: RR picks a winner among rd_req; rd_gnt[w]=1 in cycle t; fs_features_nums <= rd_nums[w] (registered).
//   - Cycle t+1: rd_vals <= fs_features_vals; rd_vld[w]=1 in cycle t+2.
//   - Latency is 2 cycles; throughput is 1 grant per cycle.
// - RR rule: search starts at last winner+1 modulo NUM_REQ; the pointer updates only on a grant.
// - Simultaneous events:
//   - load_req and rd_req in the same READY cycle: the load wins; no grant that cycle.
//   - Grants already issued still complete their rd_vld.
// - fs_features_nums holds its last value when idle and is never driven outside READY.
// - Reset mid-load or mid-read: immediate return to IDLE; no load_done or rd_vld for in-flight work.
// - Beat counter width is $clog2(CYCLES_NUM+1); no wrap, it saturates at CYCLES_NUM and clears on entering LOAD.
// CONFIGURATION
// - LOAD_TIMEOUT_EN defined:
//   - A watchdog counter clears on every dma_valid in ARMED/LOAD.
//   - When it reaches TIMEOUT: load_err pulses, fs_start=0, state -> IDLE.
// - LOAD_TIMEOUT_EN undefined: no watchdog; load_err is constant 0; a stalled load waits forever.
// STRUCTURE
// - Package gbdt_sched_pkg:
//   - sched_state_e {IDLE, ARMED, LOAD, READY, DRAIN}
//   - NUM_LANES=8, IDX_W=8, FEAT_W=9
//   - typedefs feat_idx_t, feat_val_t, lane_idx_t [NUM_LANES], lane_val_t [NUM_LANES]
// - Sub-module gbdt_rr_arbiter (parameter N): inputs req[N], en; outputs one-hot gnt[N] and the winner index; the pointer lives inside it.
// TESTING
// - Reset, then load_req, a header beat and 16 dma_valid beats back-to-back -> fs_start high exactly until the header beat; load_done exactly 1 cycle after beat 16; state READY.
// - Load with dma_valid low for 3 cycles between beats 5 and 6 -> load_done still after beat 16; load_busy high throughout.
// - READY, rd_req=4'b1111 held -> grants 0,1,2,3,0 on consecutive cycles; each rd_vld[k] 2 cycles after rd_gnt[k]; rd_vals match the store contents.
// - Lane k of requester 2 requests index 8'd37+k, where store[37+k]=9'h1A0+k -> rd_vals lane k = 9'h1A0+k with rd_vld=4'b0100.
// - load_req in the same cycle as rd_req=4'b0010 -> no grant; DRAIN for 2 cycles, then ARMED; the in-flight rd_vld from the previous grant is still delivered.
// - gbdt_rst asserted at beat 8 -> next cycle: all outputs 0, IDLE, no load_done.
// - With LOAD_TIMEOUT_EN and TIMEOUT=10: stop dma_valid at beat 4 -> load_err pulse 10 cycles later, then IDLE.

Source files
------------

// File: rtl/gbdt_sched_pkg.sv
// Shared state encoding, lane geometry and lane types for the GBDT feature-store scheduler.
package gbdt_sched_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      LOAD  = 3'd2,
      READY = 3'd3,
      DRAIN = 3'd4
   } sched_state_e;

   localparam int NUM_LANES     = 8;
   localparam int IDX_W         = 8;
   localparam int FEAT_W        = 9;
   localparam int LANE_IDX_BITS = NUM_LANES * IDX_W;
   localparam int LANE_VAL_BITS = NUM_LANES * FEAT_W;

   typedef logic [IDX_W-1:0]  feat_idx_t;
   typedef logic [FEAT_W-1:0] feat_val_t;
   typedef feat_idx_t lane_idx_t [NUM_LANES];
   typedef feat_val_t lane_val_t [NUM_LANES];

endpackage

// File: rtl/gbdt_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner; the pointer moves only on a grant.
module gbdt_rr_arbiter
   import gbdt_sched_pkg::*;
#(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic         gbdt_clk,
   input  logic         gbdt_rst,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] gnt,
   output logic [W-1:0] win
);

   logic [W-1:0] ptr;
   logic [W-1:0] cand;
   logic         found;

   always_comb begin
      gnt   = '0;
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
         cand = W'((int'(ptr) + i) % N);
         if (en && !found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            win       = cand;
         end
      end
   end

   // Reset parks the pointer on the last requester so requester 0 wins first.
   always_ff @(posedge gbdt_clk) begin
      if (gbdt_rst) begin
         ptr <= W'(N - 1);
      end else if (found) begin
         ptr <= win;
      end
   end

endmodule

// File: rtl/gbdt_feature_sched.sv
// Sequences feature-store sample loads and shares its 8-lane read port among tree engines.
// Optional load watchdog enabled by defining LOAD_TIMEOUT_EN.
module gbdt_feature_sched
   import gbdt_sched_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int CYCLES_NUM = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                              gbdt_clk,
   input  logic                              gbdt_rst,
   input  logic                              load_req,
   input  logic                              dma_valid,
   output logic                              fs_start,
   output logic [LANE_IDX_BITS-1:0]          fs_features_nums,
   input  logic [LANE_VAL_BITS-1:0]          fs_features_vals,
   output logic                              load_busy,
   output logic                              load_done,
   output logic                              load_err,
   input  logic [NUM_REQ-1:0]                rd_req,
   input  logic [NUM_REQ*LANE_IDX_BITS-1:0]  rd_nums,
   output logic [NUM_REQ-1:0]                rd_gnt,
   output logic [NUM_REQ-1:0]                rd_vld,
   output logic [LANE_VAL_BITS-1:0]          rd_vals
);

   localparam int CNT_W = $clog2(CYCLES_NUM + 1);
   localparam int RW    = $clog2(NUM_REQ);

   localparam logic [2:0] S_IDLE  = IDLE;
   localparam logic [2:0] S_ARMED = ARMED;
   localparam logic [2:0] S_LOAD  = LOAD;
   localparam logic [2:0] S_READY = READY;
   localparam logic [2:0] S_DRAIN = DRAIN;

   logic [2:0]               state, state_nx;
   logic [CNT_W-1:0]         beat_cnt, beat_nx;
   logic                     done_nx;
   logic                     arb_en;
   logic [NUM_REQ-1:0]       gnt;
   logic [RW-1:0]            win;
   logic [NUM_REQ-1:0]       vld_p0, vld_p1;
   logic [LANE_IDX_BITS-1:0] nums_p0;
   logic [LANE_VAL_BITS-1:0] vals_p1;

`ifdef LOAD_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd, wd_nx;
   logic            err_nx, err_q;
`endif

   function automatic logic [CNT_W-1:0] beat_inc(input logic [CNT_W-1:0] c);
      beat_inc = (c == CNT_W'(CYCLES_NUM)) ? c : c + 1'b1;
   endfunction

   always_comb begin
      state_nx = state;
      beat_nx  = beat_cnt;
      done_nx  = 1'b0;
      arb_en   = 1'b0;
      case (state)
         S_IDLE:  if (load_req) state_nx = S_ARMED;
         S_ARMED: if (dma_valid) begin
            state_nx = S_LOAD;
            beat_nx  = '0;
         end
         S_LOAD:  if (dma_valid) begin
            beat_nx = beat_inc(beat_cnt);
            if (beat_nx == CNT_W'(CYCLES_NUM)) begin
               state_nx = S_READY;
               done_nx  = 1'b1;
            end
         end
         // A load request in READY pre-empts any read request of the same cycle.
         S_READY: if (load_req) state_nx = S_DRAIN;
                  else          arb_en   = 1'b1;
         S_DRAIN: if (~|vld_p0 && ~|vld_p1) state_nx = S_ARMED;
         default: state_nx = S_IDLE;
      endcase
`ifdef LOAD_TIMEOUT_EN
      wd_nx  = '0;
      err_nx = 1'b0;
      if ((state == S_ARMED || state == S_LOAD) && !dma_valid) begin
         if (wd == WD_W'(TIMEOUT - 1)) begin
            err_nx   = 1'b1;
            state_nx = S_IDLE;
         end else begin
            wd_nx = wd + 1'b1;
         end
      end
`endif
   end

   gbdt_rr_arbiter #(.N(NUM_REQ)) u_arb (
      .gbdt_clk (gbdt_clk),
      .gbdt_rst (gbdt_rst),
      .req      (rd_req),
      .en       (arb_en),
      .gnt      (gnt),
      .win      (win)
   );

   always_ff @(posedge gbdt_clk) begin
      if (gbdt_rst) begin
         state     <= S_IDLE;
         beat_cnt  <= '0;
         load_done <= 1'b0;
         vld_p0    <= '0;
         vld_p1    <= '0;
`ifdef LOAD_TIMEOUT_EN
         wd        <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         beat_cnt  <= beat_nx;
         load_done <= done_nx;
         vld_p0    <= gnt;
         vld_p1    <= vld_p0;
`ifdef LOAD_TIMEOUT_EN
         wd        <= wd_nx;
         err_q     <= err_nx;
`endif
      end
   end

   // Stage p0: winner's indices drive the store; held while no grant.
   always_ff @(posedge gbdt_clk) begin
      if (gbdt_rst) begin
         nums_p0 <= '0;
      end else if (|gnt) begin
         nums_p0 <= rd_nums[int'(win)*LANE_IDX_BITS +: LANE_IDX_BITS];
      end
   end

   // Stage p1: capture the store readout for the requester granted one cycle earlier.
   always_ff @(posedge gbdt_clk) begin
      if (gbdt_rst) begin
         vals_p1 <= '0;
      end else if (|vld_p0) begin
         vals_p1 <= fs_features_vals;
      end
   end

   assign fs_start         = (state == S_ARMED);
   assign load_busy        = (state == S_ARMED) || (state == S_LOAD) || (state == S_DRAIN);
   assign rd_gnt           = gnt;
   assign rd_vld           = vld_p1;
   assign fs_features_nums = nums_p0;
   assign rd_vals          = vals_p1;

`ifdef LOAD_TIMEOUT_EN
   assign load_err = err_q;
`else
   // No watchdog in this build: TIMEOUT has no effect and the comparison is constant 0.
   assign load_err = (TIMEOUT < 0);
`endif

endmodule
